ddr_axi_memtest: RTL
====================

Name: ddr_axi_memtest

Overview:
AXI4 master traffic engine that initiates full-burst writes into the DDR3 memory controller's AXI slave port, then reads back and checks the data.
- Sits beside the MicroBlaze on the same interconnect and shares the controller clock.
- Reports pass/fail on the board LEDs and an error counter readable by firmware.

Parameters:
DATA_W, 64, AXI data width in bits; multiple of 32
ADDR_W, 30, AXI byte-address width
BASE_ADDR, 0, first byte address tested; 4 KB aligned
BURST_LEN, 16, beats per burst (1..256); BURST_LEN*DATA_W/8 <= 4096
NUM_BURSTS, 1024, bursts per phase

Ports:
ui_clk  in  1  controller UI clock; all logic on rising edge
aresetn  in  1  asynchronous active-low reset
start  in  1  begin test; sampled in IDLE
calib_done  in  1  DDR calibration complete
m_awaddr  out  ADDR_W  write burst address
m_awlen  out  8  BURST_LEN-1
m_awvalid  out  1  AW valid
m_awready  in  1  AW ready
m_wdata  out  DATA_W  write data
m_wlast  out  1  last write beat
m_wvalid  out  1  W valid
m_wready  in  1  W ready
m_bresp  in  2  write response
m_bvalid  in  1  B valid
m_bready  out  1  B ready
m_araddr  out  ADDR_W  read burst address
m_arlen  out  8  BURST_LEN-1
m_arvalid  out  1  AR valid
m_arready  in  1  AR ready
m_rdata  in  DATA_W  read data
m_rresp  in  2  read response
m_rlast  in  1  last read beat
m_rvalid  in  1  R valid
m_rready  out  1  R ready
done  out  1  test finished (led0)
pass  out  1  finished with zero errors (led1)
err_count  out  16  saturating error count
err_addr  out  ADDR_W  byte address of first error

Behaviour:
- Reset (async assert, sync release): state IDLE; every valid/ready output 0; done, pass, err_count, err_addr, burst/beat counters 0. Reset mid-transaction drops valids immediately; the AXI slave must be reset together with this block.
- Constants: AxSIZE = log2(DATA_W/8) and AxBURST = INCR are driven by the integration wrapper. WSTRB is all ones.
- FSM states: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE -> WR_ADDR only when start=1 and calib_done=1 in the same cycle. On that transition: clear done, pass, err_count, err_addr and burst_idx. start is ignored in every other state.
- Burst address = BASE_ADDR + burst_idx*BURST_BYTES, mod 2^ADDR_W. One burst outstanding at a time; no AW/W overlap.
- WR_ADDR: awvalid=1 until awready, then WR_DATA.
- WR_DATA: wvalid=1; the beat counter advances on each wvalid&wready; wlast=1 on beat BURST_LEN-1; after the last handshake go to WR_RESP.
- WR_RESP: bready=1. When bvalid arrives, bresp!=0 counts one error at the burst address. Then burst_idx++. After burst NUM_BURSTS-1, clear burst_idx and go to RD_ADDR; otherwise go to WR_ADDR.
- RD_ADDR / RD_DATA mirror the write phase with rready=1 in RD_DATA. Each beat is checked against the expected pattern.
  - Data mismatch or rresp!=0 counts one error. rlast disagreeing with the beat counter counts one additional error.
  - The burst always ends when the counter reaches BURST_LEN-1.
- Once asserted, any valid holds its address/data stable until its handshake.
- Errors: err_count saturates at 16'hFFFF. err_addr latches only on the first error of a run; the address recorded is the beat byte address.
- Pattern: for beat byte address A, 32-bit lane i = A[31:0] + i (A zero-extended). Lane 0 occupies the LSBs.
- After the last read burst go to DONE: done=1, pass = (err_count==0). Hold until the next accepted start.

Optional Feature:
MEMTEST_LOOP_EN
- Defined: adds output pass_cnt[15:0], which wraps. At the end of the read phase, if start=1 the engine increments pass_cnt and restarts WR_ADDR without clearing err_count. Odd-numbered passes use the bit-inverted pattern. done pulses high for 1 cycle per completed pass. If start=0, go to DONE as normal.
- Undefined: single pass, no pass_cnt port.

Test Plan:
- DATA_W=64, BURST_LEN=16, NUM_BURSTS=4, ideal memory model, start pulse -> exactly 4 AW (0x0, 0x80, 0x100, 0x180) and 64 W beats; beat at 0x8 = 64'h0000000900000008; then 4 AR; done=1, pass=1, err_count=0.
- Model flips rdata bit 0 of beat 0x88 -> err_count=1, err_addr=0x88, pass=0, done=1.
- Random 30% deassertion of awready/wready/arready/rvalid -> same results as the first scenario; assertions verify valid/payload stability and exactly one wlast per burst.
- bresp=SLVERR on burst 2 plus a corrupted read at 0x18 -> err_count=2, err_addr=0x100.
- start with calib_done=0 -> no AW issued, state stays IDLE. aresetn=0 during WR_DATA -> wvalid/awvalid 0 in the same cycle, done=0, err_count=0.
- MEMTEST_LOOP_EN, start held for 2 passes -> pass_cnt=2, second pass beat at 0x8 = 64'hFFFFFFF6FFFFFFF7, two done pulses, pass=1.

Source files
------------

// File: rtl/ddr_axi_memtest_if.sv
// ddr_axi_memtest_if: AXI4 AW/W/B/AR/R channel bundle between the memory test engine and the DDR controller slave port.
interface ddr_axi_memtest_if #(parameter int DATA_W = 64, parameter int ADDR_W = 30);
  logic [ADDR_W-1:0] m_awaddr;
  logic [7:0] m_awlen;
  logic m_awvalid, m_awready;
  logic [DATA_W-1:0] m_wdata;
  logic m_wlast, m_wvalid, m_wready;
  logic [1:0] m_bresp;
  logic m_bvalid, m_bready;
  logic [ADDR_W-1:0] m_araddr;
  logic [7:0] m_arlen;
  logic m_arvalid, m_arready;
  logic [DATA_W-1:0] m_rdata;
  logic [1:0] m_rresp;
  logic m_rlast, m_rvalid, m_rready;
  modport master (
    output m_awaddr, m_awlen, m_awvalid, m_wdata, m_wlast, m_wvalid, m_bready,
    output m_araddr, m_arlen, m_arvalid, m_rready,
    input m_awready, m_wready, m_bresp, m_bvalid, m_arready, m_rdata, m_rresp, m_rlast, m_rvalid
  );
  modport slave (
    input m_awaddr, m_awlen, m_awvalid, m_wdata, m_wlast, m_wvalid, m_bready,
    input m_araddr, m_arlen, m_arvalid, m_rready,
    output m_awready, m_wready, m_bresp, m_bvalid, m_arready, m_rdata, m_rresp, m_rlast, m_rvalid
  );
endinterface

// File: rtl/ddr_axi_memtest.sv
// ddr_axi_memtest: AXI4 burst write then read-back checker with saturating error count and first-error address.
// MEMTEST_LOOP_EN: adds pass_cnt and back-to-back passes while start is held, odd passes using the inverted pattern.
module ddr_axi_memtest #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 30,
  parameter int BASE_ADDR  = 0,
  parameter int BURST_LEN  = 16,
  parameter int NUM_BURSTS = 1024
) (
  input  logic               ui_clk,
  input  logic               aresetn,
  input  logic               start,
  input  logic               calib_done,
  ddr_axi_memtest_if.master  m,
  output logic               done,
  output logic               pass,
  output logic [15:0]        err_count,
  output logic [ADDR_W-1:0]  err_addr
`ifdef MEMTEST_LOOP_EN
  , output logic [15:0]      pass_cnt
`endif
);
  localparam int BYTES = DATA_W / 8;
  localparam int BW = NUM_BURSTS > 1 ? $clog2(NUM_BURSTS) : 1;
  localparam logic [7:0] LAST = 8'(BURST_LEN - 1);
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;
  state_t state_q;
  logic [BW-1:0] burst_q;
  logic [7:0] beat_q;
  logic awvalid_q, wvalid_q, wlast_q, bready_q, arvalid_q, rready_q, done_q, pass_q;
  logic [15:0] err_q, err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d, burst_addr, beat_addr;
  logic [DATA_W-1:0] pat, exp_data;
  logic [1:0] err_inc;
  logic [16:0] err_sum;
  logic inv, burst_last, beat_last, b_hs, r_hs;
`ifdef MEMTEST_LOOP_EN
  logic [15:0] pass_cnt_q;
  assign pass_cnt = pass_cnt_q;
  assign inv = pass_cnt_q[0];
`else
  assign inv = 1'b0;
`endif
  assign burst_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(burst_q) * ADDR_W'(BURST_LEN * BYTES);
  assign beat_addr = burst_addr + ADDR_W'(beat_q) * ADDR_W'(BYTES);
  always_comb begin
    pat = '0;
    for (int i = 0; i < DATA_W / 32; i++) pat[i*32 +: 32] = 32'(beat_addr) + 32'(i);
  end
  assign exp_data = pat ^ {DATA_W{inv}};
  assign burst_last = burst_q == BW'(NUM_BURSTS - 1);
  assign beat_last = beat_q == LAST;
  assign b_hs = bready_q && m.m_bvalid;
  assign r_hs = rready_q && m.m_rvalid;
  // A read beat can cost two errors: bad data/response plus a misplaced rlast.
  assign err_inc = b_hs ? {1'b0, m.m_bresp != 2'b00}
                 : r_hs ? 2'(m.m_rdata != exp_data || m.m_rresp != 2'b00) + 2'(m.m_rlast != beat_last)
                 : 2'b00;
  assign err_sum = {1'b0, err_q} + 17'(err_inc);
  assign err_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  assign err_addr_d = (err_q == 16'd0 && err_inc != 2'd0) ? beat_addr : err_addr_q;
  assign m.m_awaddr = burst_addr;
  assign m.m_araddr = burst_addr;
  assign m.m_awlen = LAST;
  assign m.m_arlen = LAST;
  assign m.m_wdata = exp_data;
  assign m.m_awvalid = awvalid_q;
  assign m.m_wvalid = wvalid_q;
  assign m.m_wlast = wlast_q;
  assign m.m_bready = bready_q;
  assign m.m_arvalid = arvalid_q;
  assign m.m_rready = rready_q;
  assign done = done_q;
  assign pass = pass_q;
  assign err_count = err_q;
  assign err_addr = err_addr_q;
  always_ff @(posedge ui_clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      burst_q <= '0;
      beat_q <= '0;
      {awvalid_q, wvalid_q, wlast_q, bready_q, arvalid_q, rready_q, done_q, pass_q} <= '0;
      err_q <= '0;
      err_addr_q <= '0;
`ifdef MEMTEST_LOOP_EN
      pass_cnt_q <= '0;
`endif
    end else begin
      err_q <= err_d;
      err_addr_q <= err_addr_d;
      case (state_q)
        IDLE, DONE: if (start && calib_done) begin
          state_q <= WR_ADDR;
          awvalid_q <= 1'b1;
          {done_q, pass_q} <= 2'b00;
          err_q <= '0;
          err_addr_q <= '0;
          burst_q <= '0;
          beat_q <= '0;
`ifdef MEMTEST_LOOP_EN
          pass_cnt_q <= '0;
`endif
        end
        WR_ADDR: begin
          done_q <= 1'b0;
          if (m.m_awready) begin
            awvalid_q <= 1'b0;
            wvalid_q <= 1'b1;
            wlast_q <= LAST == 8'd0;
            state_q <= WR_DATA;
          end
        end
        WR_DATA: if (m.m_wready) begin
          if (beat_last) begin
            beat_q <= '0;
            {wvalid_q, wlast_q} <= 2'b00;
            bready_q <= 1'b1;
            state_q <= WR_RESP;
          end else begin
            beat_q <= beat_q + 8'd1;
            wlast_q <= beat_q + 8'd1 == LAST;
          end
        end
        WR_RESP: if (b_hs) begin
          bready_q <= 1'b0;
          burst_q <= burst_last ? '0 : burst_q + BW'(1);
          awvalid_q <= !burst_last;
          arvalid_q <= burst_last;
          state_q <= burst_last ? RD_ADDR : WR_ADDR;
        end
        RD_ADDR: if (m.m_arready) begin
          arvalid_q <= 1'b0;
          rready_q <= 1'b1;
          state_q <= RD_DATA;
        end
        RD_DATA: if (r_hs) begin
          if (!beat_last) beat_q <= beat_q + 8'd1;
          else begin
            beat_q <= '0;
            rready_q <= 1'b0;
            if (!burst_last) begin
              burst_q <= burst_q + BW'(1);
              arvalid_q <= 1'b1;
              state_q <= RD_ADDR;
            end else begin
              burst_q <= '0;
              done_q <= 1'b1;
              pass_q <= err_d == 16'd0;
`ifdef MEMTEST_LOOP_EN
              pass_cnt_q <= pass_cnt_q + 16'd1;
              awvalid_q <= start;
              state_q <= start ? WR_ADDR : DONE;
`else
              state_q <= DONE;
`endif
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
